// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable, prescaled down-counter timer.
// Counts a programmed value toward zero, one step every PRESCALE clocks,
// pulses Done for one cycle at terminal count, and can auto-reload.
module down_counter_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic             Load,
   input  logic [WIDTH-1:0] Din,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Auto,
   output logic [WIDTH-1:0] Q,
   output logic             Busy,
   output logic             Done,
   output logic             Zero
);

   // A PRESCALE of 1 still needs a 1-bit prescaler so the tick compare is legal.
   localparam int               PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRE_MAX = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic [PW-1:0]    pre_q, pre_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic do_load;
   logic do_start;
   logic tick;
   logic terminal;

   // Input priority is Stop > Load > Start: only the winning input acts.
   assign do_load  = Load & ~Stop;
   assign do_start = Start & ~Stop & ~Load;
   // A tick only happens while already running and not being paused this cycle.
   assign tick     = (state_q == RUN) & ~Stop & (pre_q == PRE_MAX);
   assign terminal = tick & (q_q == ONE);

   // State register plus all datapath flops, with synchronous active-low reset.
   always_ff @(posedge Clock) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!Reset_n) begin
         state_q  <= IDLE;
         q_q      <= '0;
         reload_q <= '0;
         pre_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         q_q      <= q_d;
         reload_q <= reload_d;
         pre_q    <= pre_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // Next-state decode for the IDLE / RUN / PAUSE controller.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (do_start && (q_q != '0)) state_d = RUN;
         end
         RUN: begin
            if (Stop)                     state_d = PAUSE;
            else if (terminal && !Auto)   state_d = IDLE;
         end
         PAUSE: begin
            if (do_load)                  state_d = IDLE;
            else if (do_start)            state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Count, reload, prescaler and registered-output next values.
   always_comb begin
      q_d      = q_q;
      reload_d = reload_q;
      pre_d    = pre_q;
      done_d   = terminal;
      busy_d   = (state_d == RUN);

      if (state_q != RUN) begin
         // IDLE and PAUSE both accept a load; PAUSE keeps its phase on resume.
         if (do_load) begin
            q_d      = Din;
            reload_d = Din;
            pre_d    = '0;
         end else if (do_start && (state_q == IDLE) && (q_q != '0)) begin
            pre_d = '0;
         end
      end else if (!Stop) begin
         if (tick) begin
            pre_d = '0;
            if (q_q > ONE)     q_d = q_q - ONE;
            else if (terminal) q_d = Auto ? reload_q : '0;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   assign Q    = q_q;
   assign Busy = busy_q;
   assign Done = done_q;
   assign Zero = (q_q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed and randomized checks of down_counter_timer
// at PRESCALE=1 and PRESCALE=4, both instances driven by the same inputs.
module tb_down_counter_timer;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         Reset_n;
   logic         Load;
   logic         Start;
   logic         Stop;
   logic         Auto;
   logic [W-1:0] Din;

   logic [W-1:0] q1, q4;
   logic         busy1, done1, zero1;
   logic         busy4, done4, zero4;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   down_counter_timer #(.WIDTH(W), .PRESCALE(1)) u_p1 (
      .Clock(clk), .Reset_n(Reset_n), .Load(Load), .Din(Din), .Start(Start),
      .Stop(Stop), .Auto(Auto), .Q(q1), .Busy(busy1), .Done(done1), .Zero(zero1)
   );

   down_counter_timer #(.WIDTH(W), .PRESCALE(4)) u_p4 (
      .Clock(clk), .Reset_n(Reset_n), .Load(Load), .Din(Din), .Start(Start),
      .Stop(Stop), .Auto(Auto), .Q(q4), .Busy(busy4), .Done(done4), .Zero(zero4)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Behavioural reference: timer described by mode, count, reload value and
   // clocks elapsed in the current count period.
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   typedef struct {
      int st;
      int q;
      int rel;
      int pre;
      bit done;
   } model_t;

   model_t m1 = '{default: 0};
   model_t m4 = '{default: 0};

   function automatic model_t step(input model_t m, input bit rn, input bit ld, input bit st,
                                   input bit sp, input bit au, input int din, input int ps);
      model_t n;
      n      = m;
      n.done = 1'b0;
      if (!rn) begin
         n = '{default: 0};
      end else if (m.st == M_IDLE) begin
         if (sp) begin
         end else if (ld) begin
            n.q = din; n.rel = din; n.pre = 0;
         end else if (st && m.q != 0) begin
            n.pre = 0; n.st = M_RUN;
         end
      end else if (m.st == M_RUN) begin
         if (sp) begin
            n.st = M_PAUSE;
         end else if (m.pre + 1 == ps) begin
            n.pre = 0;
            if (m.q > 1) begin
               n.q = m.q - 1;
            end else if (m.q == 1) begin
               n.done = 1'b1;
               if (au) n.q = m.rel;
               else begin
                  n.q = 0; n.st = M_IDLE;
               end
            end
         end else begin
            n.pre = m.pre + 1;
         end
      end else begin
         if (sp) begin
         end else if (ld) begin
            n.q = din; n.rel = din; n.pre = 0; n.st = M_IDLE;
         end else if (st) begin
            n.st = M_RUN;
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m1 <= step(m1, Reset_n, Load, Start, Stop, Auto, int'(Din), 1);
      m4 <= step(m4, Reset_n, Load, Start, Stop, Auto, int'(Din), 4);
   end

   // Compare both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("p1_q",    q1,    m1.q);
         check("p1_busy", busy1, (m1.st == M_RUN));
         check("p1_done", done1, m1.done);
         check("p1_zero", zero1, (m1.q == 0));
         check("p4_q",    q4,    m4.q);
         check("p4_busy", busy4, (m4.st == M_RUN));
         check("p4_done", done4, m4.done);
         check("p4_zero", zero4, (m4.q == 0));
      end
   end

   // Drive one cycle of inputs, let the edge sample them, return #1 after it.
   task automatic apply(input bit l, input bit s, input bit p, input bit a, input int d);
      Load  = l;
      Start = s;
      Stop  = p;
      Auto  = a;
      Din   = W'(d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int first_done;
      int n_done;
      bit saw_zero;

      Reset_n = 1'b0;
      Load = 1'b0; Start = 1'b0; Stop = 1'b0; Auto = 1'b0; Din = '0;
      apply(0, 0, 0, 0, 0);
      cmp_en = 1'b1;
      apply(0, 0, 0, 0, 0);
      check("rst_q",    q1,    0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_zero", zero1, 1);
      Reset_n = 1'b1;

      // Start with Q==0 is ignored; Load+Start together only loads.
      apply(0, 1, 0, 0, 0);
      check("start_q0_busy", busy1, 0);
      check("start_q0_done", done1, 0);
      apply(1, 1, 0, 0, 4);
      check("load_start_q",    q1,    4);
      check("load_start_busy", busy1, 0);

      // PRESCALE=1 countdown from 3.
      apply(1, 0, 0, 0, 3);
      apply(0, 1, 0, 0, 0);
      check("run_busy", busy1, 1);
      check("run_q3",   q1,    3);
      apply(0, 0, 0, 0, 0);
      check("run_q2", q1, 2);
      apply(0, 0, 0, 0, 0);
      check("run_q1",         q1,    1);
      check("run_done_early", done1, 0);
      apply(0, 0, 0, 0, 0);
      check("run_q0",       q1,    0);
      check("run_done",     done1, 1);
      check("run_busy_end", busy1, 0);
      apply(0, 0, 0, 0, 0);
      check("done_pulse_width", done1, 0);
      repeat (20) apply(0, 0, 0, 0, 0);

      // PRESCALE=4: Load 2 expires 8 clocks after Start.
      apply(1, 0, 0, 0, 2);
      apply(0, 1, 0, 0, 0);
      first_done = -1;
      for (int k = 1; k <= 20; k++) begin
         apply(0, 0, 0, 0, 0);
         if (k == 3) check("p4_hold_q", q4, 2);
         if (k == 4) check("p4_tick_q", q4, 1);
         if (done4 && first_done < 0) first_done = k;
      end
      check("p4_done_latency", first_done, 8);

      // Pause after two ticks, hold with Stop for 10 cycles, then resume.
      apply(1, 0, 0, 0, 5);
      apply(0, 1, 0, 0, 0);
      apply(0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0);
      check("pre_pause_q", q1, 3);
      repeat (10) apply(0, 0, 1, 0, 0);
      check("pause_q_hold", q1,    3);
      check("pause_busy",   busy1, 0);
      apply(0, 1, 0, 0, 0);
      check("resume_busy", busy1, 1);
      first_done = -1;
      for (int k = 1; k <= 10; k++) begin
         apply(0, 0, 0, 0, 0);
         if (done1 && first_done < 0) first_done = k;
      end
      check("pause_total_latency", first_done + 13, 16);
      repeat (30) apply(0, 0, 0, 0, 0);

      // Auto-reload: Done every 3 clocks, Q never 0; then drop Auto.
      apply(1, 0, 0, 1, 3);
      apply(0, 1, 0, 1, 0);
      n_done   = 0;
      saw_zero = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         apply(0, 0, 0, 1, 0);
         if (done1) begin
            n_done++;
            check("auto_done_phase", k % 3, 0);
         end
         if (q1 == '0) saw_zero = 1'b1;
      end
      check("auto_done_count", n_done,   4);
      check("auto_never_zero", saw_zero, 0);
      check("auto_reload_q",   q1,       3);
      check("auto_busy",       busy1,    1);
      repeat (2) apply(0, 0, 0, 0, 0);
      check("auto_off_q1", q1, 1);
      apply(0, 0, 0, 0, 0);
      check("auto_off_q0",   q1,    0);
      check("auto_off_done", done1, 1);
      check("auto_off_busy", busy1, 0);
      repeat (20) apply(0, 0, 0, 0, 0);

      // Reset for one cycle while running with Q=2.
      apply(1, 0, 0, 0, 2);
      apply(0, 1, 0, 0, 0);
      check("pre_reset_q", q1, 2);
      Reset_n = 1'b0;
      apply(0, 0, 0, 0, 0);
      Reset_n = 1'b1;
      check("mid_reset_q",    q1,    0);
      check("mid_reset_busy", busy1, 0);
      check("mid_reset_done", done1, 0);
      n_done = 0;
      repeat (5) begin
         apply(0, 0, 0, 0, 0);
         if (done1) n_done++;
      end
      check("mid_reset_no_done", n_done, 0);

      // Randomized traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 4000; i++) begin
         Reset_n = ($urandom_range(0, 99) != 0);
         apply($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 25,
               $urandom_range(0, 99) < 8,  $urandom_range(0, 99) < 60,
               $urandom_range(0, 15));
      end
      Reset_n = 1'b1;
      repeat (2) apply(0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
